matmul_tile_scheduler: RTL and testbench
========================================

Name: matmul_tile_scheduler

Overview:
- Sequences a large matrix multiply as a series of NxN tile multiplies on the systolic array.
- Sits between the controller's start/address registers and the array's start_mul/stall_mul handshake.
- Walks the row-tile, column-tile and inner-tile loops, generating x/w/y scratchpad addresses and an accumulate flag for each tile.
- Issues one tile at a time and waits for completion before issuing the next.

Parameters:
- N, 64, systolic array dimension; one tile is NxN 32-bit words.
- TILE_BYTES, N*N*4, byte stride between consecutive tiles in the scratchpad.
- DIM_W, 8, width of the tile-count configuration fields.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  begin job; sampled in IDLE only
- x_base  input  32  input matrix base address
- w_base  input  32  weight matrix base address
- y_base  input  32  output matrix base address
- m_tiles  input  DIM_W  row tiles of X/Y
- n_tiles  input  DIM_W  column tiles of W/Y
- k_tiles  input  DIM_W  inner-dimension tiles
- abort  input  1  stop after the current tile
- stall_mul  input  1  high while the array is computing
- start_mul  output  1  one-cycle tile issue pulse
- x_addr  output  32  current X tile address
- w_addr  output  32  current W tile address
- y_addr  output  32  current Y tile address
- accumulate  output  1  0 means overwrite Y; 1 means add into Y
- busy  output  1  job in progress
- done  output  1  one-cycle job-complete pulse
- err  output  1  sticky: last job had a zero dimension or was aborted
- tiles_done  output  16  tiles completed in the current or last job

Behaviour:
- Reset values: all outputs 0. State is IDLE and all counters are 0.
- Configuration inputs are latched on the accepted start. Later changes are ignored until the next job.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - start=1 with any dimension 0 -> FINISH; err set, no tile issued.
  - start=1 otherwise -> ISSUE; err and tiles_done cleared, i=j=k=0, busy=1.
  - start while busy is ignored.
- ISSUE (1 cycle): start_mul=1 -> WAIT_ACK.
  - Addresses and accumulate are valid in this cycle and stay stable until the tile completes (NEXT).
- WAIT_ACK: stall_mul=1 -> WAIT_DONE. Waits indefinitely; there is no timeout.
- WAIT_DONE: stall_mul=0 -> NEXT; tiles_done increments (saturates at 16'hFFFF).
- NEXT: advance the loop: k innermost, then j, then i outermost.
  - If all tiles are done or abort has been seen -> FINISH, otherwise -> ISSUE.
  - abort=1 seen in any busy state is latched and sets err.
- FINISH (1 cycle): done=1, busy=0 -> IDLE.
- Address arithmetic, modulo 2^32, wrap permitted:
  - x_addr = x_base + (i*k_tiles + k)*TILE_BYTES
  - w_addr = w_base + (k*n_tiles + j)*TILE_BYTES
  - y_addr = y_base + (i*n_tiles + j)*TILE_BYTES
- accumulate = (k != 0).
- Incremental pointer updates are preferred over multipliers; outputs must match the formulas exactly.
- Tile issue order: (i,j,k) lexicographic.
- Total tiles = m*n*k (at most 255^3, which exceeds 16 bits; tiles_done saturates).
- Minimum per-tile overhead: ISSUE + WAIT_ACK + WAIT_DONE + NEXT = 4 cycles, with stall_mul asserted the cycle after start_mul and held 1 cycle.
- Reset mid-job: immediate return to IDLE with all outputs 0; no done pulse.

Test Plan:
- N=4 (TILE_BYTES=64), m=n=k=1, bases 0x100/0x200/0x300; array model asserts stall 1 cycle after start_mul for 5 cycles -> one start_mul, addrs 0x100/0x200/0x300, accumulate=0, done pulse, tiles_done=1, err=0.
- m=2, n=2, k=2, bases 0 -> 8 issues in order (0,0,0),(0,0,1),(0,1,0)...; 4th issue (i=0,j=1,k=1): x=0x40, w=0xC0, y=0x40, accumulate=1; 5th issue (i=1,j=0,k=0): x=0x80, y=0x80, accumulate=0; tiles_done=8.
- start with k_tiles=0 -> no start_mul, done pulse 2 cycles after start, err=1, tiles_done=0.
- m=n=k=2, abort pulsed during the 3rd tile's WAIT_DONE -> 3rd tile completes, no 4th start_mul, done=1, err=1, tiles_done=3.
- start re-pulsed while busy with new bases; stall_mul held high 20 cycles -> ignored, addresses unchanged, start_mul not repeated.
- n_rst asserted during WAIT_DONE -> all outputs 0 asynchronously, no done pulse; a new job then runs normally from i=j=k=0.
- x_base=0xFFFF_FFC0, N=4, m=1, k=2 -> second tile x_addr=0x0000_0000 (wrap).

Source files
------------

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler
//   Breaks a large matrix multiply into NxN tile multiplies for the systolic
//   array. It walks the (i, j, k) tile loops (k innermost) and issues one tile
//   at a time. For each tile it presents the X/W/Y scratchpad addresses and an
//   accumulate flag, then waits for the array to finish before moving on.
//
// Ports
//   clk, n_rst           clock, asynchronous active-low reset
//   start                begin a job (sampled in IDLE only)
//   x_base/w_base/y_base matrix base addresses (latched on accepted start)
//   m_tiles/n_tiles/k_tiles  tile counts (latched on accepted start)
//   abort                finish the current tile, then stop the job
//   stall_mul            high while the array computes a tile
//   start_mul            one-cycle tile issue pulse
//   x_addr/w_addr/y_addr current tile addresses
//   accumulate           0 = overwrite Y, 1 = add into Y
//   busy, done           job in progress / one-cycle completion pulse
//   err                  sticky: last job had a zero dimension or was aborted
//   tiles_done           saturating count of completed tiles in this job
module matmul_tile_scheduler #(
    parameter int N          = 64,
    parameter int TILE_BYTES = N * N * 4,
    parameter int DIM_W      = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [31:0]      x_base,
    input  logic [31:0]      w_base,
    input  logic [31:0]      y_base,
    input  logic [DIM_W-1:0] m_tiles,
    input  logic [DIM_W-1:0] n_tiles,
    input  logic [DIM_W-1:0] k_tiles,
    input  logic             abort,
    input  logic             stall_mul,
    output logic             start_mul,
    output logic [31:0]      x_addr,
    output logic [31:0]      w_addr,
    output logic [31:0]      y_addr,
    output logic             accumulate,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      tiles_done
);

    localparam logic [31:0] TB = 32'(TILE_BYTES);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH
    } state_t;

    state_t           state;
    logic [DIM_W-1:0] m_r, n_r, k_r;
    logic [DIM_W-1:0] i, j, k;
    logic [31:0]      w_base_r;
    logic [31:0]      x_row;     // x_base + i*k_tiles*TB
    logic [31:0]      w_col;     // w_base + j*TB
    logic [31:0]      w_kstride; // n_tiles*TB
    logic             abort_seen;
    logic             k_last, j_last, i_last;

    always_comb begin
        k_last = (k == k_r - 1'b1);
        j_last = (j == n_r - 1'b1);
        i_last = (i == m_r - 1'b1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            m_r        <= '0;
            n_r        <= '0;
            k_r        <= '0;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            w_base_r   <= '0;
            x_row      <= '0;
            w_col      <= '0;
            w_kstride  <= '0;
            abort_seen <= 1'b0;
            start_mul  <= 1'b0;
            x_addr     <= '0;
            w_addr     <= '0;
            y_addr     <= '0;
            accumulate <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            tiles_done <= '0;
        end else begin
            start_mul <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tiles_done <= '0;
                        abort_seen <= 1'b0;
                        if (m_tiles == '0 || n_tiles == '0 || k_tiles == '0) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            start_mul  <= 1'b1;
                            state      <= ISSUE;
                            m_r        <= m_tiles;
                            n_r        <= n_tiles;
                            k_r        <= k_tiles;
                            i          <= '0;
                            j          <= '0;
                            k          <= '0;
                            w_base_r   <= w_base;
                            w_kstride  <= 32'(n_tiles) * TB;
                            x_row      <= x_base;
                            x_addr     <= x_base;
                            w_col      <= w_base;
                            w_addr     <= w_base;
                            y_addr     <= y_base;
                            accumulate <= 1'b0;
                        end
                    end
                end
                ISSUE: state <= WAIT_ACK;
                WAIT_ACK: begin
                    if (stall_mul) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!stall_mul) begin
                        state <= NEXT;
                        if (tiles_done != '1) tiles_done <= tiles_done + 16'd1;
                    end
                end
                NEXT: begin
                    if ((i_last && j_last && k_last) || abort_seen || abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        start_mul <= 1'b1;
                        state     <= ISSUE;
                        // Pointers advance incrementally. Y is row-major over
                        // (i, j), so it simply steps by one tile whenever j moves.
                        // X at the end of a row plus one tile is the next row start.
                        if (!k_last) begin
                            k          <= k + 1'b1;
                            x_addr     <= x_addr + TB;
                            w_addr     <= w_addr + w_kstride;
                            accumulate <= 1'b1;
                        end else begin
                            k          <= '0;
                            accumulate <= 1'b0;
                            y_addr     <= y_addr + TB;
                            if (!j_last) begin
                                j      <= j + 1'b1;
                                x_addr <= x_row;
                                w_col  <= w_col + TB;
                                w_addr <= w_col + TB;
                            end else begin
                                j      <= '0;
                                i      <= i + 1'b1;
                                x_row  <= x_addr + TB;
                                x_addr <= x_addr + TB;
                                w_col  <= w_base_r;
                                w_addr <= w_base_r;
                            end
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (abort && (state == ISSUE || state == WAIT_ACK ||
                          state == WAIT_DONE || state == NEXT)) begin
                abort_seen <= 1'b1;
                err        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
module tb_matmul_tile_scheduler;

    localparam int N        = 4;
    localparam int TB_BYTES = N * N * 4;
    localparam int DIM_W    = 8;
    localparam int BUDGET   = 3000;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic [31:0]      x_base, w_base, y_base;
    logic [DIM_W-1:0] m_tiles, n_tiles, k_tiles;
    logic             abort;
    logic             stall_mul;
    logic             start_mul;
    logic [31:0]      x_addr, w_addr, y_addr;
    logic             accumulate, busy, done, err;
    logic [15:0]      tiles_done;

    always #5 clk = ~clk;

    matmul_tile_scheduler #(.N(N), .TILE_BYTES(TB_BYTES), .DIM_W(DIM_W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .x_base(x_base), .w_base(w_base), .y_base(y_base),
        .m_tiles(m_tiles), .n_tiles(n_tiles), .k_tiles(k_tiles),
        .abort(abort), .stall_mul(stall_mul), .start_mul(start_mul),
        .x_addr(x_addr), .w_addr(w_addr), .y_addr(y_addr),
        .accumulate(accumulate), .busy(busy), .done(done), .err(err),
        .tiles_done(tiles_done)
    );

    typedef struct {
        logic [31:0] x, w, y;
        logic        acc;
    } tile_t;

    tile_t exp_q[$];
    tile_t cur;
    bit    have_cur = 0;
    int    errors = 0, checks = 0, issues = 0, done_cnt = 0;
    int    hold_override = 0;
    bit    fixed_timing = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Array model: acknowledges each start_mul by raising stall_mul for a while.
    initial begin
        int d;
        int h;
        stall_mul = 1'b0;
        forever begin
            @(negedge clk);
            if (start_mul === 1'b1) begin
                d = fixed_timing ? 0 : int'($urandom_range(0, 2));
                h = (hold_override > 0) ? hold_override : int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                @(posedge clk);
                #1 stall_mul = 1'b1;
                repeat (h) @(posedge clk);
                #1 stall_mul = 1'b0;
            end
        end
    end

    // Issue monitor: every start_mul is matched against the reference order,
    // and addresses must stay put while the tile is outstanding.
    initial begin
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                have_cur = 0;
            end else begin
                if (start_mul) begin
                    issues++;
                    check("busy_at_issue", 32'(busy), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("extra_issue", 32'(issues), 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        check("x_addr", x_addr, cur.x);
                        check("w_addr", w_addr, cur.w);
                        check("y_addr", y_addr, cur.y);
                        check("accumulate", 32'(accumulate), 32'(cur.acc));
                    end
                end else if (busy && have_cur) begin
                    check("x_stable", x_addr, cur.x);
                    check("w_stable", w_addr, cur.w);
                    check("y_stable", y_addr, cur.y);
                end
                if (done) done_cnt++;
            end
        end
    end

    // Reference: tiles in (i,j,k) lexicographic order from the address formulas.
    task automatic kick(input int m, input int n, input int k,
                        input logic [31:0] xb, input logic [31:0] wb, input logic [31:0] yb,
                        input int limit);
        int    cnt;
        tile_t t;
        cnt = 0;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                for (int kk = 0; kk < k; kk++)
                    if (limit == 0 || cnt < limit) begin
                        t.x   = xb + 32'((i * k + kk) * TB_BYTES);
                        t.w   = wb + 32'((kk * n + j) * TB_BYTES);
                        t.y   = yb + 32'((i * n + j) * TB_BYTES);
                        t.acc = (kk != 0);
                        exp_q.push_back(t);
                        cnt++;
                    end
        @(posedge clk);
        #1;
        m_tiles = DIM_W'(m); n_tiles = DIM_W'(n); k_tiles = DIM_W'(k);
        x_base = xb; w_base = wb; y_base = yb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble configuration: the job must run on the latched values.
        m_tiles = DIM_W'($urandom); n_tiles = DIM_W'($urandom); k_tiles = DIM_W'($urandom);
        x_base = $urandom; w_base = $urandom; y_base = $urandom;
    endtask

    // lat counts cycles with the start cycle as cycle 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_issues(input int n);
        for (int c = 0; c < BUDGET; c++) begin
            if (issues >= n) return;
            @(negedge clk);
        end
        check("issue_timeout", 32'(issues), 32'(n));
    endtask

    task automatic wait_stall();
        for (int c = 0; c < BUDGET; c++) begin
            if (stall_mul) return;
            @(negedge clk);
        end
        check("stall_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_checks(input int exp_tiles, input bit exp_err, input int pre_done);
        int d0;
        check("tiles_done", 32'(tiles_done), 32'(exp_tiles));
        check("err", 32'(err), 32'(exp_err));
        check("busy_at_done", 32'(busy), 32'd0);
        check("leftover_issues", 32'(exp_q.size()), 32'd0);
        #1;
        d0 = done_cnt;
        check("done_count", 32'(done_cnt - pre_done), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("done_pulse_width", 32'(done_cnt - d0), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_job(input int m, input int n, input int k,
                           input logic [31:0] xb, input logic [31:0] wb, input logic [31:0] yb,
                           input bit chk_lat);
        int lat, pre, tiles;
        bit zero;
        zero  = (m == 0 || n == 0 || k == 0);
        tiles = zero ? 0 : m * n * k;
        pre   = done_cnt;
        kick(m, n, k, xb, wb, yb, 0);
        wait_done(lat);
        // Minimum handshake: 4 cycles per tile plus start and finish cycles.
        if (chk_lat) check("done_latency", 32'(lat), 32'(2 + 4 * tiles));
        finish_checks(tiles, zero, pre);
    endtask

    initial begin
        int lat, pre, m, n, k;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        x_base = '0; w_base = '0; y_base = '0;
        m_tiles = '0; n_tiles = '0; k_tiles = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", x_addr | w_addr | y_addr, 32'd0);
        check("rst_flags", 32'({start_mul, accumulate, busy, done, err, tiles_done}), 32'd0);
        n_rst = 1'b1;

        // Single tile, array holds stall for 5 cycles.
        fixed_timing = 1; hold_override = 5;
        run_job(1, 1, 1, 32'h100, 32'h200, 32'h300, 0);

        // 2x2x2 at minimum handshake timing.
        hold_override = 1;
        run_job(2, 2, 2, 32'h0, 32'h0, 32'h0, 1);

        // Zero inner dimension: no issue, error, done in cycle 2.
        run_job(1, 1, 0, 32'h1000, 32'h2000, 32'h3000, 1);

        // Address wrap on X.
        run_job(1, 1, 2, 32'hFFFF_FFC0, 32'h40, 32'h80, 1);

        // Abort during the third tile's WAIT_DONE.
        hold_override = 4;
        pre = done_cnt;
        issues = 0;
        kick(2, 2, 2, 32'h0, 32'h0, 32'h0, 3);
        wait_issues(3);
        wait_stall();
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done(lat);
        finish_checks(3, 1, pre);

        // Start re-pulsed while busy, long stall.
        hold_override = 20;
        pre = done_cnt;
        issues = 0;
        kick(1, 1, 1, 32'hA000, 32'hB000, 32'hC000, 0);
        wait_issues(1);
        repeat (3) @(posedge clk);
        #1;
        x_base = 32'h5555_0000; w_base = 32'h6666_0000; y_base = 32'h7777_0000;
        m_tiles = 2; n_tiles = 2; k_tiles = 2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check("restart_issues", 32'(issues), 32'd1);
        finish_checks(1, 0, pre);

        // Reset during WAIT_DONE, then a clean job.
        hold_override = 4;
        pre = done_cnt;
        issues = 0;
        kick(2, 2, 2, 32'h400, 32'h800, 32'hC00, 0);
        wait_issues(2);
        wait_stall();
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("midrst_addr", x_addr | w_addr | y_addr, 32'd0);
        check("midrst_flags", 32'({start_mul, accumulate, busy, done, err, tiles_done}), 32'd0);
        repeat (30) @(posedge clk);
        check("midrst_no_done", 32'(done_cnt - pre), 32'd0);
        exp_q.delete();
        #1 n_rst = 1'b1;
        hold_override = 1;
        run_job(2, 2, 2, 32'h400, 32'h800, 32'hC00, 1);

        // Randomized jobs with random array timing.
        fixed_timing = 0; hold_override = 0;
        for (int r = 0; r < 10; r++) begin
            m = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
            n = int'($urandom_range(1, 3));
            k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
            run_job(m, n, k, $urandom, $urandom, $urandom, 0);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
